// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that shares one fixed-point divider among NUM_REQ requesters.
// Divide-by-zero requests are answered locally without touching the core.
module div_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*10-1:0] req_dividend,
  input  logic [NUM_REQ*3-1:0]  req_divisor,
  output logic                  core_in_valid,
  output logic [9:0]            core_in_data_1,
  output logic [2:0]            core_in_data_2,
  input  logic                  core_out_valid,
  input  logic [19:0]           core_out_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [19:0]           rsp_data,
  output logic                  rsp_dz
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [9:0]      op_a_q, op_a_d;
  logic [2:0]      op_b_q, op_b_d;
  logic [19:0]     data_q, data_d;
  logic            dz_q, dz_d;
  logic            in_valid_q, in_valid_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [9:0]      sel_a;
  logic [2:0]      sel_b;

  // Search above rr_ptr first, then wrap around to 0..rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (i > int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (i <= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_a = req_dividend[i*10 +: 10];
        sel_b = req_divisor[i*3 +: 3];
      end
      req_ready[i] = (state_q == StIdle) && win_found && (win_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    data_d   = data_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_id;
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          if (sel_b == 3'd0) begin
            data_d  = 20'hFFFFF;
            dz_d    = 1'b1;
            state_d = StResp;
          end else begin
            dz_d    = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (core_out_valid) begin
          data_d  = core_out_data;
          dz_d    = 1'b0;
          state_d = StDrain;
        end
      end
      // The core holds out_valid for several cycles; reissuing before it drops is illegal.
      StDrain: begin
        if (!core_out_valid) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rr_ptr_d = grant_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    in_valid_d  = (state_d == StIssue);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      grant_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      data_q      <= '0;
      dz_q        <= 1'b0;
      in_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      data_q      <= data_d;
      dz_q        <= dz_d;
      in_valid_q  <= in_valid_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign core_in_valid  = in_valid_q;
  assign core_in_data_1 = op_a_q;
  assign core_in_data_2 = op_b_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = grant_q;
  assign rsp_data       = data_q;
  assign rsp_dz         = dz_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter with a behavioural multi-cycle divider core.
module tb_div_share_arbiter;

  localparam int LAT = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [19:0] data;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_dividend;
  logic [11:0] req_divisor;
  logic        core_in_valid;
  logic [9:0]  core_in_data_1;
  logic [2:0]  core_in_data_2;
  logic        core_out_valid;
  logic [19:0] core_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [19:0] rsp_data;
  logic        rsp_dz;

  int   checks = 0;
  int   errors = 0;
  int   issue_cnt = 0;
  exp_t exp_q[$];
  int   order[5] = '{0, 1, 2, 3, 0};

  div_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .core_in_valid (core_in_valid),
    .core_in_data_1(core_in_data_1),
    .core_in_data_2(core_in_data_2),
    .core_out_valid(core_out_valid),
    .core_out_data (core_out_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_dz        (rsp_dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Divider model: LAT compute cycles reading the operands each cycle, then out_valid for 2 cycles.
  initial begin
    bit         m_busy;
    int         m_cnt;
    int         m_hold;
    logic [9:0] m_a;
    logic [2:0] m_b;
    m_busy = 0; m_cnt = 0; m_hold = 0; m_a = '0; m_b = '0;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_cnt = 0; m_hold = 0;
        core_out_valid <= 1'b0;
        core_out_data  <= '0;
      end else if (core_in_valid) begin
        issue_cnt++;
        check("single_issue", 32'(m_busy || m_hold > 0), 32'd0);
        m_busy = 1; m_cnt = LAT; m_a = core_in_data_1; m_b = core_in_data_2;
      end else begin
        if (m_busy || m_hold > 0)
          check("operand_hold", 32'({core_in_data_1, core_in_data_2}), 32'({m_a, m_b}));
        if (m_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 0;
            m_hold = 2;
            core_out_valid <= 1'b1;
            core_out_data  <= (core_in_data_2 == 3'd0) ? 20'hFFFFF :
                              20'((32'(core_in_data_1) * 1024) / 32'(core_in_data_2));
          end
        end else if (m_hold > 0) begin
          m_hold--;
          if (m_hold == 0) core_out_valid <= 1'b0;
        end
      end
    end
  end

  // Monitor: every response handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id=%0d data=%h dz=%0b, required no response",
                   rsp_id, rsp_data, rsp_dz);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 32'({rsp_id, rsp_data, rsp_dz}), 32'(e));
        end
      end
    end
  end

  task automatic issue(input int id, input logic [9:0] dd, input logic [2:0] dv,
                       input logic [19:0] exp_data, input logic exp_dz, input bit push);
    bit got = 1'b0;
    req_dividend[id*10 +: 10] = dd;
    req_divisor[id*3 +: 3]    = dv;
    req_valid[id]             = 1'b1;
    if (push) exp_q.push_back('{id: 2'(id), data: exp_data, dz: exp_dz});
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    check("accept", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_core"}, 32'({core_in_valid, core_in_data_1, core_in_data_2}), 32'd0);
    check({name, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_data, rsp_dz, req_ready}), 32'd0);
  endtask

  initial begin
    int n;
    int c;
    int base;
    bit got;
    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Round robin from reset: requester 0 first, data = dividend << 10.
    for (int i = 0; i < 4; i++) begin
      req_dividend[i*10 +: 10] = 10'(10 * (i + 1));
      req_divisor[i*3 +: 3]    = 3'd1;
    end
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{id: 2'(order[k]), data: 20'((10 * (order[k] + 1)) << 10), dz: 1'b0});
    req_valid = 4'hF;
    n = 0;
    c = 0;
    while (n < 5 && c < 400) begin
      @(negedge clk);
      c++;
      if (|(req_valid & req_ready)) begin
        check("rr_order", 32'(req_ready), 32'(4'b0001 << order[n]));
        n++;
        if (n == 5) begin
          @(posedge clk);
          #1 req_valid = '0;
        end
      end
    end
    check("rr_grants", 32'(n), 32'd5);
    wait_drain();

    // Single op: 100*1024/4 = 25600.
    base = issue_cnt;
    issue(0, 10'd100, 3'd4, 20'h06400, 1'b0, 1'b1);
    wait_drain();
    check("t1_pulses", 32'(issue_cnt - base), 32'd1);

    // Divide by zero answered one cycle after accept, core untouched.
    base = issue_cnt;
    issue(1, 10'd7, 3'd0, 20'hFFFFF, 1'b1, 1'b1);
    @(negedge clk);
    check("dz_latency", 32'(rsp_valid), 32'd1);
    check("dz_core_idle", 32'(core_in_valid), 32'd0);
    wait_drain();
    check("dz_pulses", 32'(issue_cnt - base), 32'd0);

    // Backpressure: 60*1024/5 = 12288 held while rsp_ready=0, then req0 (8/1) follows.
    rsp_ready = 1'b0;
    exp_q.push_back('{id: 2'd3, data: 20'h03000, dz: 1'b0});
    exp_q.push_back('{id: 2'd0, data: 20'h02000, dz: 1'b0});
    req_dividend[30 +: 10] = 10'd60;
    req_divisor[9 +: 3]    = 3'd5;
    req_valid[3]           = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("bp_rsp_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    req_valid[3]          = 1'b0;
    req_dividend[0 +: 10] = 10'd8;
    req_divisor[0 +: 3]   = 3'd1;
    req_valid[0]          = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_data, rsp_dz}), 32'({1'b1, 2'd3, 20'h03000, 1'b0}));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_core_idle", 32'(core_in_valid), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1'b1;
    end
    check("bp_next_grant", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_drain();

    // Operand hold with the largest operands: 1023*1024/7 = 149650 (truncated).
    issue(2, 10'd1023, 3'd7, 20'h24892, 1'b0, 1'b1);
    wait_drain();

    // Reset during WAIT drops the in-flight request.
    issue(1, 10'd5, 3'd5, 20'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("reset_mid");
      @(posedge clk);
    end
    #1 rst = 1'b0;
    issue(0, 10'd9, 3'd3, 20'h00C00, 1'b0, 1'b1);
    wait_drain();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
